// File: rtl/instr_mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_loader_pkg
//   Shared pipeline definitions used by the instruction-memory loader and the
//   fetch/decode halt detection.
//   - load_state_t   : loader FSM state encoding (IDLE=0 ... ERROR=4)
//   - HALT_INSTR     : instruction value that terminates a program
//   - BYTES_PER_WORD : bytes assembled into one 32-bit instruction
//   - BYTE_CNT_W     : width of a byte-within-word counter
// ---------------------------------------------------------------------------
package instr_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } load_state_t;

    localparam logic [31:0] HALT_INSTR     = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_WORD = 4;
    localparam int          BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/instr_mem_loader_byte_to_word_assembler.sv
// ---------------------------------------------------------------------------
// byte_to_word_assembler
//   Collects a big-endian byte stream into NBITS-wide words. The first byte
//   of a word ends up in the most significant position.
//   Ports:
//     clk, rst_n   : clock and asynchronous active-low reset
//     clear        : synchronous clear of the partial word and byte counter
//     enable       : bytes are only taken while enable is high
//     byte_in      : received byte
//     byte_valid   : byte_in is valid this cycle
//     word_out     : assembled word, valid in the cycle word_ready is high
//     word_ready   : high in the cycle the final byte of a word is presented
//     byte_count   : bytes already held for the current word
// ---------------------------------------------------------------------------
module byte_to_word_assembler
    import instr_mem_loader_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic [NBITS-1:0]      word_out,
    output logic                  word_ready,
    output logic [BYTE_CNT_W-1:0] byte_count
);

    // Only the bytes that precede the final one need storing; the final byte
    // is appended combinationally so the word is usable on the same edge.
    logic [NBITS-9:0] shift_reg;
    logic             take_byte;

    assign take_byte  = enable && byte_valid;
    assign word_out   = {shift_reg, byte_in};
    assign word_ready = take_byte && (byte_count == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    // Shift each accepted byte in from the bottom; the counter wraps to zero
    // once a complete word has been handed over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            byte_count <= '0;
        end else if (clear) begin
            shift_reg  <= '0;
            byte_count <= '0;
        end else if (take_byte) begin
            shift_reg  <= word_out[NBITS-9:0];
            byte_count <= word_ready ? '0 : byte_count + 1'b1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//   Receives a program as a byte stream from the debug/UART path and writes
//   it into instruction memory as 32-bit words at byte addresses 0, 4, 8, ...
//   A load stops after the HALT instruction has been written (DONE), or on
//   memory overflow / inter-byte timeout (ERROR). While loading, o_busy keeps
//   the fetch stage disabled.
//   Ports:
//     i_clk, i_reset   : clock and asynchronous active-low reset
//     i_start          : one-cycle pulse that begins a load
//     i_rx_data        : received byte
//     i_rx_valid       : one-cycle strobe qualifying i_rx_data
//     o_mem_wr_en      : one-cycle instruction-memory write strobe
//     o_mem_wr_addr    : byte address of the write (word index * 4)
//     o_mem_wr_data    : instruction word to write
//     o_busy           : high while receiving or writing
//     o_done           : load finished with HALT written
//     o_error          : load aborted on overflow or timeout
//     o_word_count     : words written in the current or last load
// ---------------------------------------------------------------------------
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int               NBITS          = 32,
    parameter int               MEM_DEPTH      = 64,
    parameter logic [NBITS-1:0] HALT_WORD      = HALT_INSTR,
    parameter int               TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic [7:0]                  i_rx_data,
    input  logic                        i_rx_valid,
    output logic                        o_mem_wr_en,
    output logic [NBITS-1:0]            o_mem_wr_addr,
    output logic [NBITS-1:0]            o_mem_wr_data,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_error,
    output logic [$clog2(MEM_DEPTH):0]  o_word_count
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W = $clog2(MEM_DEPTH) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_INDEX    = IDX_W'(MEM_DEPTH - 1);
    localparam logic [TMO_W-1:0] TIMEOUT_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    load_state_t             state;
    logic [IDX_W-1:0]        word_index;
    logic [TMO_W-1:0]        timeout_cnt;
    logic [TMO_W-1:0]        timeout_next;
    logic                    start_load;
    logic                    asm_enable;
    logic [NBITS-1:0]        asm_word;
    logic                    asm_word_ready;
    logic [BYTE_CNT_W-1:0]   asm_byte_count;

    // A start pulse is honoured only from the resting states, and it takes
    // priority over any byte strobe arriving in the same cycle.
    assign start_load   = i_start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    assign asm_enable   = (state == ST_RECV);
    assign timeout_next = timeout_cnt + 1'b1;

    byte_to_word_assembler #(
        .NBITS (NBITS)
    ) u_assembler (
        .clk        (i_clk),
        .rst_n      (i_reset),
        .clear      (start_load),
        .enable     (asm_enable),
        .byte_in    (i_rx_data),
        .byte_valid (i_rx_valid),
        .word_out   (asm_word),
        .word_ready (asm_word_ready),
        .byte_count (asm_byte_count)
    );

    // Loader FSM. All outputs are registered here. The write strobe is raised
    // on the edge that samples the final byte, so WRITE lasts exactly the one
    // cycle in which o_mem_wr_en is high. The timeout only runs while a word
    // is partially assembled; between words the loader waits indefinitely.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= ST_IDLE;
            word_index    <= '0;
            timeout_cnt   <= '0;
            o_mem_wr_en   <= 1'b0;
            o_mem_wr_addr <= '0;
            o_mem_wr_data <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            o_word_count  <= '0;
        end else begin
            o_mem_wr_en <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_load) begin
                        state        <= ST_RECV;
                        word_index   <= '0;
                        timeout_cnt  <= '0;
                        o_word_count <= '0;
                        o_busy       <= 1'b1;
                        o_done       <= 1'b0;
                        o_error      <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (asm_word_ready) begin
                        state         <= ST_WRITE;
                        timeout_cnt   <= '0;
                        o_mem_wr_en   <= 1'b1;
                        o_mem_wr_addr <= NBITS'(word_index) << 2;
                        o_mem_wr_data <= asm_word;
                    end else if (i_rx_valid) begin
                        timeout_cnt <= '0;
                    end else if (asm_byte_count != '0) begin
                        timeout_cnt <= timeout_next;
                        if (timeout_next == TIMEOUT_LIMIT) begin
                            state   <= ST_ERROR;
                            o_busy  <= 1'b0;
                            o_error <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    o_word_count <= o_word_count + CNT_W'(1);
                    if (o_mem_wr_data == HALT_WORD) begin
                        state  <= ST_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else if (word_index == LAST_INDEX) begin
                        state   <= ST_ERROR;
                        o_busy  <= 1'b0;
                        o_error <= 1'b1;
                    end else begin
                        state      <= ST_RECV;
                        word_index <= word_index + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
//   Self-checking bench for instr_mem_loader (MEM_DEPTH=4, TIMEOUT_CYCLES=16).
//   A table of complete loads and randomized loads are checked against a
//   word-level model of the load rules; multi-cycle corner cases (latency,
//   timeout, reset mid-load, ignored strobes) are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

    localparam int          NBITS     = 32;
    localparam int          MEM_DEPTH = 4;
    localparam int          TIMEOUT   = 16;
    localparam int          WCW       = $clog2(MEM_DEPTH) + 1;
    localparam logic [31:0] HALT      = 32'hFFFF_FFFF;

    typedef struct {
        logic [127:0] words;
        int           nWords;
        logic         expDone;
        logic         expErr;
        int           expCount;
    } vector_t;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             start    = 1'b0;
    logic [7:0]       rx_data  = 8'h00;
    logic             rx_valid = 1'b0;
    logic             wr_en;
    logic [NBITS-1:0] wr_addr;
    logic [NBITS-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             error;
    logic [WCW-1:0]   word_count;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [63:0] wrLog[$];
    logic [31:0] stimWords[$];
    logic [63:0] expWr[$];
    logic        expDone;
    logic        expErr;
    int          expCount;
    int          logStart;
    vector_t     vecs[5];

    instr_mem_loader #(
        .NBITS          (NBITS),
        .MEM_DEPTH      (MEM_DEPTH),
        .HALT_WORD      (HALT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_start       (start),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .o_mem_wr_en   (wr_en),
        .o_mem_wr_addr (wr_addr),
        .o_mem_wr_data (wr_data),
        .o_busy        (busy),
        .o_done        (done),
        .o_error       (error),
        .o_word_count  (word_count)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Record every memory write seen, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en) wrLog.push_back({wr_addr, wr_data});
    end

    // Hard stop in case a sequence never returns.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected test to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Word-level model: words are written in order from address 0 until the
    // HALT word has been written or the last memory word has been used.
    task automatic modelLoad();
        expWr.delete();
        expDone  = 1'b0;
        expErr   = 1'b0;
        expCount = 0;
        for (int i = 0; i < stimWords.size(); i++) begin
            if (expDone || expErr) break;
            expWr.push_back({32'(i * 4), stimWords[i]});
            expCount++;
            if (stimWords[i] == HALT) expDone = 1'b1;
            else if (i == MEM_DEPTH - 1) expErr = 1'b1;
        end
    endtask

    // All driving tasks start and end just after a falling edge.
    task automatic sendByte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitTerminal(input int maxCycles);
        int n = 0;
        while (!(done || error) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("terminated", 32'(done || error), 32'd1);
    endtask

    // Start a load and stream stimWords big-endian; gap < 0 picks a random
    // idle gap per byte. Streaming stops once the loader has finished.
    task automatic applyStimulus(input int gap);
        logic [31:0] w;
        int          g;
        pulseStart();
        checkOutput("busyAfterStart", 32'(busy), 32'd1);
        checkOutput("doneClearedOnStart", 32'(done), 32'd0);
        checkOutput("errorClearedOnStart", 32'(error), 32'd0);
        checkOutput("countClearedOnStart", 32'(word_count), 32'd0);
        for (int i = 0; i < stimWords.size(); i++) begin
            if (done || error) break;
            w = stimWords[i];
            for (int b = 0; b < 4; b++) begin
                g = (gap < 0) ? int'($urandom_range(1, 3)) : gap;
                sendByte(w[31 - 8*b -: 8], g);
            end
        end
        waitTerminal(40);
    endtask

    task automatic runLoad(input string tag, input int gap);
        logic [63:0] got;
        int          nNew;
        logStart = wrLog.size();
        modelLoad();
        applyStimulus(gap);
        nNew = wrLog.size() - logStart;
        checkOutput({tag, "_done"}, 32'(done), 32'(expDone));
        checkOutput({tag, "_error"}, 32'(error), 32'(expErr));
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_count"}, 32'(word_count), 32'(expCount));
        checkOutput({tag, "_nwrites"}, 32'(nNew), 32'(expWr.size()));
        for (int i = 0; i < expWr.size() && i < nNew; i++) begin
            got = wrLog[logStart + i];
            checkOutput($sformatf("%s_addr%0d", tag, i), got[63:32], expWr[i][63:32]);
            checkOutput($sformatf("%s_data%0d", tag, i), got[31:0], expWr[i][31:0]);
        end
    endtask

    initial begin
        vecs[0] = '{{32'h2001_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0}, 3, 1'b1, 1'b0, 3};
        vecs[1] = '{{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004}, 4, 1'b0, 1'b1, 4};
        vecs[2] = '{{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0}, 1, 1'b1, 1'b0, 1};
        vecs[3] = '{{32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 32'h0}, 2, 1'b1, 1'b0, 2};
        vecs[4] = '{{32'h0000_000A, 32'h0000_000B, 32'h0000_000C, 32'hFFFF_FFFF}, 4, 1'b1, 1'b0, 4};

        // Reset state, checked while reset is held.
        #12;
        checkOutput("rstWrEn", 32'(wr_en), 32'd0);
        checkOutput("rstAddr", wr_addr, 32'd0);
        checkOutput("rstData", wr_data, 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstError", 32'(error), 32'd0);
        checkOutput("rstCount", 32'(word_count), 32'd0);
        #8;
        rst_n = 1'b1;

        // Byte strobes in IDLE are ignored.
        for (int b = 0; b < 4; b++) sendByte(8'hA0 + 8'(b), 1);
        checkOutput("idleNoWrites", 32'(wrLog.size()), 32'd0);
        checkOutput("idleCount", 32'(word_count), 32'd0);
        checkOutput("idleBusy", 32'(busy), 32'd0);

        // Table-driven complete loads.
        for (int v = 0; v < 5; v++) begin
            stimWords.delete();
            for (int i = 0; i < vecs[v].nWords; i++)
                stimWords.push_back(vecs[v].words[127 - 32*i -: 32]);
            runLoad($sformatf("vec%0d", v), 1);
            checkOutput($sformatf("vec%0d_tblDone", v), 32'(done), 32'(vecs[v].expDone));
            checkOutput($sformatf("vec%0d_tblError", v), 32'(error), 32'(vecs[v].expErr));
            checkOutput($sformatf("vec%0d_tblCount", v), 32'(word_count), 32'(vecs[v].expCount));
        end

        // Byte strobes in DONE are ignored and DONE is sticky.
        logStart = wrLog.size();
        for (int b = 0; b < 4; b++) sendByte(8'h55, 1);
        checkOutput("doneNoWrites", 32'(wrLog.size() - logStart), 32'd0);
        checkOutput("doneCountKept", 32'(word_count), 32'd4);
        checkOutput("doneSticky", 32'(done), 32'd1);

        // Endianness and write latency.
        logStart = wrLog.size();
        pulseStart();
        sendByte(8'h12, 1);
        sendByte(8'h34, 1);
        sendByte(8'h56, 1);
        rx_valid = 1'b1;
        rx_data  = 8'h78;
        checkOutput("latNoEarlyWrite", 32'(wr_en), 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
        checkOutput("latWrEn", 32'(wr_en), 32'd1);
        checkOutput("latAddr", wr_addr, 32'h0);
        checkOutput("latData", wr_data, 32'h1234_5678);
        @(negedge clk);
        checkOutput("latOneCycle", 32'(wr_en), 32'd0);
        for (int b = 0; b < 4; b++) sendByte(8'hFF, 1);
        waitTerminal(40);
        checkOutput("latWrites", 32'(wrLog.size() - logStart), 32'd2);

        // Timeout: two bytes, then silence.
        logStart = wrLog.size();
        pulseStart();
        sendByte(8'hAB, 1);
        rx_valid = 1'b1;
        rx_data  = 8'hCD;
        @(negedge clk);
        rx_valid = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (k == TIMEOUT - 1) checkOutput("tmoNotYet", 32'(error), 32'd0);
            if (k == TIMEOUT) checkOutput("tmoError", 32'(error), 32'd1);
        end
        checkOutput("tmoBusy", 32'(busy), 32'd0);
        checkOutput("tmoDone", 32'(done), 32'd0);
        checkOutput("tmoNoWrite", 32'(wrLog.size() - logStart), 32'd0);

        // Recovery after timeout starts again from address 0.
        stimWords = '{32'hCAFE_F00D, HALT};
        runLoad("tmoRecover", 1);

        // Reset in the middle of a load.
        pulseStart();
        for (int b = 0; b < 6; b++) sendByte(8'h11 * 8'(b + 1), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstWrEn", 32'(wr_en), 32'd0);
        checkOutput("midRstAddr", wr_addr, 32'd0);
        checkOutput("midRstData", wr_data, 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstDone", 32'(done), 32'd0);
        checkOutput("midRstError", 32'(error), 32'd0);
        checkOutput("midRstCount", 32'(word_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stimWords = '{32'h0BAD_BEEF, HALT};
        runLoad("afterRst", 1);

        // Randomized loads with random inter-byte gaps.
        for (int r = 0; r < 8; r++) begin
            stimWords.delete();
            for (int i = 0; i < 5; i++)
                stimWords.push_back(($urandom_range(0, 3) == 0) ? HALT : 32'($urandom));
            runLoad($sformatf("rand%0d", r), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
